elevator_scan_ctrl: RTL and testbench

Parametrised elevator car controller: latches floor calls into a pending mask and drives one car with a SCAN (keep direction while calls lie ahead) policy. Travel time per floor and door dwell are timed in cycles. It extends the idle-state choose/up/down direction FSM with a configurable floor count, request latching, a door state and timed motion. It sits between the call-button synchroniser and the motor/door drivers.

---
 rtl/elevator_scan_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_scan_ctrl
//
// Single-car elevator controller using a SCAN policy: the car keeps its
// direction of travel while calls lie ahead of it and only reverses when
// nothing is left in that direction. Floor calls are latched into a pending
// mask. Travel time per floor and door dwell time are counted in cycles.
//
// Ports:
//   clock          in   rising-edge clock for all state
//   reset          in   synchronous, active-high reset
//   call_req       in   [FLOORS]  new floor calls this cycle (any number set)
//   pending        out  [FLOORS]  latched outstanding calls
//   current_floor  out  [FLOOR_W] floor the car is at, or last passed
//   moving         out  high while in MOVING
//   direction      out  1 = up, 0 = down; holds while not moving
//   door_open      out  high while in DOOR
//   arrived        out  one-cycle pulse on the first DOOR cycle
//
// Every output is a register or a decode of the state register, so there is
// no combinational path from call_req to any output.
// ---------------------------------------------------------------------------
module elevator_scan_ctrl #(
  parameter int FLOORS      = 8,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [FLOORS-1:0]  call_req,
  output logic [FLOORS-1:0]  pending,
  output logic [FLOOR_W-1:0] current_floor,
  output logic               moving,
  output logic               direction,
  output logic               door_open,
  output logic               arrived
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DOOR   = 2'd2
  } state_t;

  localparam int CNT_W   = $clog2(FLOORS + 1);
  localparam int T_MAX   = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  // Timers only ever hold values 0..T_MAX-1.
  localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TIMER_W-1:0] MOVE_LOAD = TIMER_W'(MOVE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

  // State registers
  state_t               state_reg,   state_next;
  logic [FLOORS-1:0]    pending_reg, pending_next;
  logic [FLOOR_W-1:0]   floor_reg,   floor_next;
  logic                 dir_reg,     dir_next;
  logic [TIMER_W-1:0]   timer_reg,   timer_next;
  logic                 arrived_reg, arrived_next;

  // Request bookkeeping
  logic [FLOORS-1:0]    above_mask, below_mask;
  logic [CNT_W-1:0]     above_cnt,  below_cnt;
  logic                 above_any,  below_any;
  logic                 ahead_any,  behind_any;
  logic [FLOOR_W-1:0]   hop_floor;
  logic [FLOORS-1:0]    pending_set, clear_mask;
  logic                 clear_en;
  logic [FLOOR_W-1:0]   clear_floor;

  // Pending calls split by side of the car.
  for (genvar gi = 0; gi < FLOORS; gi++) begin : g_side
    assign above_mask[gi] = pending_reg[gi] && (FLOOR_W'(gi) > floor_reg);
    assign below_mask[gi] = pending_reg[gi] && (FLOOR_W'(gi) < floor_reg);
  end

  assign above_any = |above_mask;
  assign below_any = |below_mask;

  // Call counts on each side; only the IDLE direction choice needs them.
  always_comb begin
    above_cnt = '0;
    below_cnt = '0;
    for (int i = 0; i < FLOORS; i++) begin
      above_cnt = above_cnt + CNT_W'(above_mask[i]);
      below_cnt = below_cnt + CNT_W'(below_mask[i]);
    end
  end

  // Floor reached at the end of the current hop. The ends are clamped even
  // though a pending target ahead always stops the car before them.
  always_comb begin
    hop_floor = floor_reg;
    if (dir_reg) begin
      if (floor_reg != TOP_FLOOR) hop_floor = floor_reg + FLOOR_W'(1);
    end else begin
      if (floor_reg != '0) hop_floor = floor_reg - FLOOR_W'(1);
    end
  end

  // ---------------- state register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      floor_reg   <= '0;
      dir_reg     <= 1'b1;
      timer_reg   <= '0;
      arrived_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      floor_reg   <= floor_next;
      dir_reg     <= dir_next;
      timer_reg   <= timer_next;
      arrived_reg <= arrived_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next   = state_reg;
    floor_next   = floor_reg;
    dir_next     = dir_reg;
    timer_next   = timer_reg;
    arrived_next = 1'b0;
    pending_set  = call_req;
    clear_en     = 1'b0;
    clear_floor  = floor_reg;
    ahead_any    = dir_reg ? above_any : below_any;
    behind_any   = dir_reg ? below_any : above_any;

    case (state_reg)
      IDLE: begin
        if (pending_reg[floor_reg]) begin
          state_next   = DOOR;
          timer_next   = DOOR_LOAD;
          arrived_next = 1'b1;
          clear_en     = 1'b1;
        end else if (above_any || below_any) begin
          state_next = MOVING;
          timer_next = MOVE_LOAD;
          // Majority side wins; a tie goes up.
          dir_next   = (below_cnt > above_cnt) ? 1'b0 : 1'b1;
        end
      end

      MOVING: begin
        if (timer_reg != '0) begin
          timer_next = timer_reg - TIMER_W'(1);
        end else begin
          floor_next = hop_floor;
          if (pending_reg[hop_floor]) begin
            state_next   = DOOR;
            timer_next   = DOOR_LOAD;
            arrived_next = 1'b1;
            clear_en     = 1'b1;
            clear_floor  = hop_floor;
          end else begin
            timer_next = MOVE_LOAD;
          end
        end
      end

      DOOR: begin
        // A call for the floor the door is open at is absorbed as a reopen
        // instead of being latched.
        pending_set[floor_reg] = 1'b0;
        if (call_req[floor_reg]) begin
          timer_next = DOOR_LOAD;
        end else if (timer_reg != '0) begin
          timer_next = timer_reg - TIMER_W'(1);
        end else if (ahead_any) begin
          state_next = MOVING;
          timer_next = MOVE_LOAD;
        end else if (behind_any) begin
          state_next = MOVING;
          dir_next   = ~dir_reg;
          timer_next = MOVE_LOAD;
        end else begin
          state_next = IDLE;
          timer_next = '0;
        end
      end

      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase

    // Clearing the arrival floor overrides a same-edge call for that floor.
    clear_mask   = clear_en ? (FLOORS'(1) << clear_floor) : '0;
    pending_next = (pending_reg | pending_set) & ~clear_mask;
  end

  // ---------------- output decode ----------------
  always_comb begin
    pending       = pending_reg;
    current_floor = floor_reg;
    direction     = dir_reg;
    arrived       = arrived_reg;
    moving        = (state_reg == MOVING);
    door_open     = (state_reg == DOOR);
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_elevator_scan_ctrl
//
// Drives two controllers (8 floors / 3-bit index, 16 floors / 4-bit index).
// Cycle-exact checks come from a table of rows: each row gives the inputs
// driven during one cycle and the outputs expected in that same cycle
// (-1 = not checked). Longer SCAN sequences push the expected arrivals
// (floor, pending, direction) into a queue that is popped on each arrived
// pulse.
// ---------------------------------------------------------------------------
module tb_elevator_scan_ctrl;

  localparam int X = -1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-floor instance
  logic        rst8 = 1'b1;
  logic [7:0]  call8 = '0;
  logic [7:0]  pend8;
  logic [2:0]  floor8;
  logic        mov8, dir8, door8, arr8;

  // 16-floor instance
  logic        rst16 = 1'b1;
  logic [15:0] call16 = '0;
  logic [15:0] pend16;
  logic [3:0]  floor16;
  logic        mov16, dir16, door16, arr16;

  elevator_scan_ctrl #(.FLOORS(8), .FLOOR_W(3), .MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut8 (
    .clock(clk), .reset(rst8), .call_req(call8), .pending(pend8),
    .current_floor(floor8), .moving(mov8), .direction(dir8),
    .door_open(door8), .arrived(arr8)
  );

  elevator_scan_ctrl #(.FLOORS(16), .FLOOR_W(4), .MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut16 (
    .clock(clk), .reset(rst16), .call_req(call16), .pending(pend16),
    .current_floor(floor16), .moving(mov16), .direction(dir16),
    .door_open(door16), .arrived(arr16)
  );

  typedef struct {
    int    grp;
    int    at;
    int    dut;
    int    rst;
    int    call;
    string name;
    int    pend, floor, mov, dir, door, arr;
  } row_t;

  typedef struct {
    int    cyc;
    int    dut;
    string name;
    int    pend, floor, mov, dir, door, arr;
  } exp_t;

  typedef struct {
    string name;
    int    floor, pend, dir;
  } arr_t;

  row_t rows[$];
  exp_t exp_q[$];
  arr_t arr_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   arr_en = 1'b0;

  function automatic void add_row(int grp, int at, int dut, int rst, int call, string nm,
                                  int p, int f, int m, int d, int dr, int a);
    row_t r;
    r.grp = grp; r.at = at; r.dut = dut; r.rst = rst; r.call = call; r.name = nm;
    r.pend = p; r.floor = f; r.mov = m; r.dir = d; r.door = dr; r.arr = a;
    rows.push_back(r);
  endfunction

  task automatic chk(string nm, string field, int act, int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        failures++;
        $display("FAIL %s.%s got=%0h expected=%0h (cycle %0d)", nm, field, act, exp, cyc);
      end
    end
  endtask

  task automatic push_now(int dut, string nm, int p, int f, int m, int d, int dr, int a);
    exp_t e;
    e.cyc = cyc; e.dut = dut; e.name = nm;
    e.pend = p; e.floor = f; e.mov = m; e.dir = d; e.door = dr; e.arr = a;
    exp_q.push_back(e);
  endtask

  task automatic push_arr(string nm, int f, int p, int d);
    arr_t a;
    a.name = nm; a.floor = f; a.pend = p; a.dir = d;
    arr_q.push_back(a);
  endtask

  // Compare everything due this cycle at the falling edge.
  task automatic sample();
    exp_t e;
    arr_t a;
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      if (e.dut == 0) begin
        chk(e.name, "pending", int'(pend8), e.pend);
        chk(e.name, "floor",   int'(floor8), e.floor);
        chk(e.name, "moving",  int'(mov8), e.mov);
        chk(e.name, "dir",     int'(dir8), e.dir);
        chk(e.name, "door",    int'(door8), e.door);
        chk(e.name, "arrived", int'(arr8), e.arr);
      end else begin
        chk(e.name, "pending", int'(pend16), e.pend);
        chk(e.name, "floor",   int'(floor16), e.floor);
        chk(e.name, "moving",  int'(mov16), e.mov);
        chk(e.name, "dir",     int'(dir16), e.dir);
        chk(e.name, "door",    int'(door16), e.door);
        chk(e.name, "arrived", int'(arr16), e.arr);
      end
    end
    if (arr_en && arr8) begin
      checks++;
      if (arr_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_arrival got_floor=%0d expected=none (cycle %0d)", floor8, cyc);
      end else begin
        checks--;
        a = arr_q.pop_front();
        $display("arrival %s floor=%0d pending=%0h dir=%0d cycle=%0d", a.name, floor8, pend8, dir8, cyc);
        chk(a.name, "arr_floor",   int'(floor8), a.floor);
        chk(a.name, "arr_pending", int'(pend8), a.pend);
        chk(a.name, "arr_dir",     int'(dir8), a.dir);
      end
    end
  endtask

  // Advance to the next cycle; inputs are pulses unless driven again.
  task automatic step();
    @(posedge clk);
    #1;
    call8 = '0; call16 = '0; rst8 = 1'b0; rst16 = 1'b0;
  endtask

  task automatic idle_cycles(int n);
    repeat (n) begin
      sample();
      step();
    end
  endtask

  task automatic run_group(int g);
    int base;
    base = cyc;
    foreach (rows[r]) begin
      if (rows[r].grp == g) begin
        while (cyc < base + rows[r].at) begin
          sample();
          step();
        end
        if (rows[r].dut == 0) begin
          rst8 = rows[r].rst[0];
          call8 = rows[r].call[7:0];
        end else begin
          rst16 = rows[r].rst[0];
          call16 = rows[r].call[15:0];
        end
        $display("row %s t+%0d call=%0h rst=%0d", rows[r].name, rows[r].at, rows[r].call, rows[r].rst);
        push_now(rows[r].dut, rows[r].name, rows[r].pend, rows[r].floor, rows[r].mov,
                 rows[r].dir, rows[r].door, rows[r].arr);
      end
    end
    sample();
    step();
  endtask

  task automatic wait_arrivals(string nm, int budget);
    int n;
    n = 0;
    while (arr_q.size() > 0 && n < budget) begin
      sample();
      step();
      n++;
    end
    if (arr_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: %0d arrivals outstanding, required 0", nm, arr_q.size());
      arr_q.delete();
    end
  endtask

  // Drive a call on the 8-floor car and wait until the queued arrivals occur,
  // then check the car has gone idle at the last served floor.
  task automatic scan_call(string nm, int call, int last_floor, int last_dir);
    call8 = call[7:0];
    $display("scan %s call=%0h", nm, call);
    sample();
    step();
    wait_arrivals(nm, 400);
    idle_cycles(2);
    push_now(0, {nm, "_idle"}, 0, last_floor, 0, last_dir, 0, 0);
    sample();
    step();
  endtask

  initial begin
    // grp 0: reset with all calls asserted
    add_row(0, 0, 0, 1, 'hFF, "rst_hold",  X, X, X, X, X, X);
    add_row(0, 1, 0, 1, 'hFF, "rst_1",     0, 0, 0, 1, 0, 0);
    add_row(0, 2, 0, 0, 'h00, "rst_2",     0, 0, 0, 1, 0, 0);
    add_row(0, 3, 0, 0, 'h00, "rst_3",     0, 0, 0, 1, 0, 0);
    // grp 1: single trip 0 -> 3
    add_row(1, 0,  0, 0, 'h08, "trip_t0",  0,   0, 0, 1, 0, 0);
    add_row(1, 1,  0, 0, 'h00, "trip_t1",  'h08, 0, 0, 1, 0, 0);
    add_row(1, 2,  0, 0, 'h00, "trip_t2",  'h08, 0, 1, 1, 0, 0);
    add_row(1, 5,  0, 0, 'h00, "trip_t5",  'h08, 0, 1, 1, 0, 0);
    add_row(1, 6,  0, 0, 'h00, "trip_t6",  'h08, 1, 1, 1, 0, 0);
    add_row(1, 10, 0, 0, 'h00, "trip_t10", 'h08, 2, 1, 1, 0, 0);
    add_row(1, 13, 0, 0, 'h00, "trip_t13", 'h08, 2, 1, 1, 0, 0);
    add_row(1, 14, 0, 0, 'h00, "trip_t14", 0,   3, 0, 1, 1, 1);
    add_row(1, 15, 0, 0, 'h00, "trip_t15", 0,   3, 0, 1, 1, 0);
    add_row(1, 16, 0, 0, 'h00, "trip_t16", 0,   3, 0, 1, 1, 0);
    add_row(1, 17, 0, 0, 'h00, "trip_t17", 0,   3, 0, 1, 0, 0);
    // grp 2: door at floor 3, reopen call lands at the edge into door cycle 2
    add_row(2, 0, 0, 0, 'h08, "reo_t0", 0,   3, 0, X, 0, 0);
    add_row(2, 1, 0, 0, 'h00, "reo_t1", 'h08, 3, 0, X, 0, 0);
    add_row(2, 2, 0, 0, 'h08, "reo_d1", 0,   3, 0, X, 1, 1);
    add_row(2, 3, 0, 0, 'h00, "reo_d2", 0,   3, 0, X, 1, 0);
    add_row(2, 4, 0, 0, 'h00, "reo_d3", 0,   3, 0, X, 1, 0);
    add_row(2, 5, 0, 0, 'h00, "reo_d4", 0,   3, 0, X, 1, 0);
    add_row(2, 6, 0, 0, 'h00, "reo_end", 0,  3, 0, X, 0, 0);
    // grp 3: reset while moving between floors 2 and 3
    add_row(3, 0,  0, 1, 'h00, "mrst_pre",  X,   X, X, X, X, X);
    add_row(3, 1,  0, 0, 'h08, "mrst_call", 0,   0, 0, 1, 0, 0);
    add_row(3, 12, 0, 1, 'h00, "mrst_hit",  'h08, 2, 1, 1, 0, 0);
    add_row(3, 13, 0, 0, 'h00, "mrst_t13",  0,   0, 0, 1, 0, 0);
    add_row(3, 14, 0, 0, 'h00, "mrst_t14",  0,   0, 0, 1, 0, 0);
    // grp 4: 16-floor car, single trip 0 -> 15
    add_row(4, 0,  1, 1, 'h0000, "f16_rst", X,      X,  X, X, X, X);
    add_row(4, 1,  1, 0, 'h8000, "f16_t0",  0,      0,  0, 1, 0, 0);
    add_row(4, 2,  1, 0, 'h0000, "f16_t1",  'h8000, 0,  0, 1, 0, 0);
    add_row(4, 3,  1, 0, 'h0000, "f16_t2",  'h8000, 0,  1, 1, 0, 0);
    add_row(4, 6,  1, 0, 'h0000, "f16_t5",  'h8000, 0,  1, 1, 0, 0);
    add_row(4, 7,  1, 0, 'h0000, "f16_t6",  'h8000, 1,  1, 1, 0, 0);
    add_row(4, 35, 1, 0, 'h0000, "f16_t34", 'h8000, 8,  1, 1, 0, 0);
    add_row(4, 62, 1, 0, 'h0000, "f16_t61", 'h8000, 14, 1, 1, 0, 0);
    add_row(4, 63, 1, 0, 'h0000, "f16_t62", 0,      15, 0, 1, 1, 1);
    add_row(4, 64, 1, 0, 'h0000, "f16_t63", 0,      15, 0, 1, 1, 0);
    add_row(4, 65, 1, 0, 'h0000, "f16_t64", 0,      15, 0, 1, 1, 0);
    add_row(4, 66, 1, 0, 'h0000, "f16_t65", 0,      15, 0, 1, 0, 0);

    run_group(0);
    run_group(1);
    run_group(2);

    arr_en = 1'b1;
    // SCAN hold: heading up from 3 to 6; a call for 2 appears between 4 and 5.
    call8 = 8'h40;
    push_arr("scan_6", 6, 'h04, 1);
    push_arr("scan_2", 2, 'h00, 0);
    $display("scan scan_hold call=40");
    sample();
    step();
    idle_cycles(6);
    call8 = 8'h04;
    $display("scan scan_hold call=04");
    sample();
    step();
    wait_arrivals("scan_hold", 400);
    idle_cycles(2);
    push_now(0, "scan_hold_idle", 0, 2, 0, 0, 0, 0);
    sample();
    step();

    // Position at 4, then majority-below call: serve 1, 0, then reverse to 7.
    push_arr("to4_a", 4, 'h00, 1);
    scan_call("to4_a", 'h10, 4, 1);
    push_arr("maj_1", 1, 'h81, 0);
    push_arr("maj_0", 0, 'h80, 0);
    push_arr("maj_7", 7, 'h00, 1);
    scan_call("maj", 'h83, 7, 1);
    // Back to 4, then one call each side: tie goes up.
    push_arr("to4_b", 4, 'h00, 0);
    scan_call("to4_b", 'h10, 4, 0);
    push_arr("tie_7", 7, 'h08, 1);
    push_arr("tie_3", 3, 'h00, 0);
    scan_call("tie", 'h88, 3, 0);
    arr_en = 1'b0;

    run_group(3);
    run_group(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
